// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry and the architecturally fixed registers.
package cpu_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may occur in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    pop_data = mem[rd_ptr];
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between execute writeback and non-stallable load
// returns, and keeps the per-register busy scoreboard used for decode hazard stalls.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_data,
  output logic              a_ready,
  input  logic              ld_issue_valid,
  input  logic [AW-1:0]     ld_issue_addr,
  output logic              ld_issue_ready,
  input  logic              ld_ret_valid,
  input  logic [DW-1:0]     ld_ret_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [2**AW-1:0]  busy_mask,
  output logic              err_ret
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              tag_push, tag_pop, tag_empty, tag_full;
  logic [AW-1:0]     tag_head;
  logic [CW-1:0]     tag_count;
  logic              wb_push, wb_pop, wb_empty, wb_full;
  logic [AW+DW-1:0]  wb_head;
  logic [CW-1:0]     wb_count;
  logic [CW:0]       outstanding;
  logic              issue_fire;
  logic              a_fire;
  logic              vld_p0;
  logic [AW-1:0]     addr_p0;
  logic [DW-1:0]     data_p0;

  sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) tag_q (
    .clock(clock), .reset(reset),
    .push(tag_push), .push_data(ld_issue_addr),
    .pop(tag_pop), .pop_data(tag_head),
    .count(tag_count), .empty(tag_empty), .full(tag_full)
  );

  sync_fifo #(.WIDTH(AW + DW), .DEPTH(DEPTH)) wb_q (
    .clock(clock), .reset(reset),
    .push(wb_push), .push_data({tag_head, ld_ret_data}),
    .pop(wb_pop), .pop_data(wb_head),
    .count(wb_count), .empty(wb_empty), .full(wb_full)
  );

  // Stage p0: issue/return bookkeeping and write-port arbitration (load returns win).
  always_comb begin
    outstanding    = {1'b0, tag_count} + {1'b0, wb_count};
    ld_issue_ready = !reset && (outstanding < (CW+1)'(DEPTH)) && !tag_full && !wb_full
                     && !busy_mask[ld_issue_addr];
    issue_fire     = ld_issue_valid && ld_issue_ready;
    tag_push       = issue_fire;
    tag_pop        = !reset && ld_ret_valid && !tag_empty;
    wb_push        = tag_pop;
    wb_pop         = !reset && !wb_empty;
    a_ready        = !reset && wb_empty && !busy_mask[a_addr];
    a_fire         = a_valid && a_ready;
    vld_p0         = wb_pop || a_fire;
    addr_p0        = wb_pop ? wb_head[AW+DW-1:DW] : a_addr;
    data_p0        = wb_pop ? wb_head[DW-1:0]     : a_data;
  end

  // Stage p1: registered write port, scoreboard and sticky return error.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy_mask <= '0;
      err_ret   <= 1'b0;
    end else begin
      wr_en <= vld_p0 && (addr_p0 != AW'(REG_ZERO));
      if (vld_p0) begin
        wr_addr <= addr_p0;
        wr_data <= data_p0;
      end
      if (ld_ret_valid && tag_empty) err_ret <= 1'b1;
      if (wb_pop) busy_mask[wb_head[AW+DW-1:DW]] <= 1'b0;
      // Issue to a register being cleared is blocked by busy, so these never collide.
      if (issue_fire && (ld_issue_addr != AW'(REG_ZERO))) busy_mask[ld_issue_addr] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_addr;
  logic        ld_issue_ready;
  logic        ld_ret_valid;
  logic [31:0] ld_ret_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy_mask;
  logic        err_ret;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr),
    .ld_issue_ready(ld_issue_ready),
    .ld_ret_valid(ld_ret_valid), .ld_ret_data(ld_ret_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_mask(busy_mask), .err_ret(err_ret)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [4:0]  ia;
    logic        rv;
    logic [31:0] rd;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic        ar;
    logic        ir;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        err;
    logic [4:0]  bi;
    logic        bv;
  } vec_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: loads in flight are just two ordered lists.
  logic [4:0]  m_tq[$];
  wb_t         m_wq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_err;
  logic [4:0]  wlog[$];

  function automatic stim_t S(input logic rst, input logic iv, input logic [4:0] ia,
                              input logic rv, input logic [31:0] rd,
                              input logic av, input logic [4:0] aa, input logic [31:0] ad);
    S = '{rst: rst, iv: iv, ia: ia, rv: rv, rd: rd, av: av, aa: aa, ad: ad};
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    foreach (m_tq[i]) if (m_tq[i] != 5'd0) m[m_tq[i]] = 1'b1;
    foreach (m_wq[i]) if (m_wq[i].a != 5'd0) m[m_wq[i].a] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_cycle(input stim_t s);
    logic [31:0] mb;
    logic exp_ir, exp_ar;
    wb_t e;
    @(negedge clock);
    reset = s.rst; ld_issue_valid = s.iv; ld_issue_addr = s.ia;
    ld_ret_valid = s.rv; ld_ret_data = s.rd;
    a_valid = s.av; a_addr = s.aa; a_data = s.ad;
    #1;
    mb     = model_busy();
    exp_ir = !s.rst && (m_tq.size() + m_wq.size() < DEPTH) && !mb[s.ia];
    exp_ar = !s.rst && (m_wq.size() == 0) && !mb[s.aa];
    chk("m_a_ready", a_ready, exp_ar);
    chk("m_ld_issue_ready", ld_issue_ready, exp_ir);
    chk("m_wr_en", wr_en, m_we);
    chk("m_wr_addr", wr_addr, m_wa);
    chk("m_wr_data", wr_data, m_wd);
    chk("m_err_ret", err_ret, m_err);
    chk("m_busy_mask", busy_mask, mb);
    if (wr_en) wlog.push_back(wr_addr);
    if (s.rst) begin
      m_tq.delete(); m_wq.delete();
      m_we = 0; m_wa = '0; m_wd = '0; m_err = 0;
    end else begin
      m_we = 0;
      if (m_wq.size() > 0) begin
        e = m_wq.pop_front();
        m_we = (e.a != 5'd0); m_wa = e.a; m_wd = e.d;
      end else if (s.av && exp_ar) begin
        m_we = (s.aa != 5'd0); m_wa = s.aa; m_wd = s.ad;
      end
      if (s.rv) begin
        if (m_tq.size() > 0) m_wq.push_back('{a: m_tq.pop_front(), d: s.rd});
        else m_err = 1;
      end
      if (s.iv && exp_ir) m_tq.push_back(s.ia);
    end
  endtask

  stim_t idle;
  stim_t rs;
  vec_t  vt[20];

  initial begin
    idle = S(0, 0, 0, 0, 0, 0, 0, 0);
    rs   = S(1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1; a_valid = 0; a_addr = 0; a_data = 0;
    ld_issue_valid = 0; ld_issue_addr = 0; ld_ret_valid = 0; ld_ret_data = 0;
    m_we = 0; m_wa = 0; m_wd = 0; m_err = 0;
    repeat (2) @(posedge clock);

    vt[0]  = '{rs,                                      0,1'b0,0,5'd0,32'h0,0,5'd8,0};
    vt[1]  = '{S(0,0,0,0,0,1,5,32'h1234),               1,1,0,5'd0,32'h0,0,5'd8,0};
    vt[2]  = '{S(0,1,8,0,0,0,0,0),                      1,1,1,5'd5,32'h1234,0,5'd8,0};
    vt[3]  = '{idle,                                    1,1,0,5'd5,32'h1234,0,5'd8,1};
    vt[4]  = '{idle,                                    1,1,0,5'd5,32'h1234,0,5'd8,1};
    vt[5]  = '{S(0,0,0,1,32'hDEAD_BEEF,0,0,0),          1,1,0,5'd5,32'h1234,0,5'd8,1};
    vt[6]  = '{idle,                                    0,1,0,5'd5,32'h1234,0,5'd8,1};
    vt[7]  = '{idle,                                    1,1,1,5'd8,32'hDEAD_BEEF,0,5'd8,0};
    vt[8]  = '{S(0,1,9,0,0,0,0,0),                      1,1,0,5'd8,32'hDEAD_BEEF,0,5'd9,0};
    vt[9]  = '{S(0,1,9,0,0,1,9,32'hAA),                 0,0,0,5'd8,32'hDEAD_BEEF,0,5'd9,1};
    vt[10] = '{S(0,1,9,1,32'h99,1,9,32'hAA),            0,0,0,5'd8,32'hDEAD_BEEF,0,5'd9,1};
    vt[11] = '{S(0,1,9,0,0,1,9,32'hAA),                 0,0,0,5'd8,32'hDEAD_BEEF,0,5'd9,1};
    vt[12] = '{S(0,0,0,0,0,1,9,32'hAA),                 1,1,1,5'd9,32'h99,0,5'd9,0};
    vt[13] = '{idle,                                    1,1,1,5'd9,32'hAA,0,5'd9,0};
    vt[14] = '{S(0,0,0,0,0,1,0,32'hFFFF),               1,1,0,5'd9,32'hAA,0,5'd0,0};
    vt[15] = '{idle,                                    1,1,0,5'd0,32'hFFFF,0,5'd0,0};
    vt[16] = '{S(0,0,0,1,32'h5,0,0,0),                  1,1,0,5'd0,32'hFFFF,0,5'd0,0};
    vt[17] = '{idle,                                    1,1,0,5'd0,32'hFFFF,1,5'd0,0};
    vt[18] = '{rs,                                      0,0,0,5'd0,32'hFFFF,1,5'd0,0};
    vt[19] = '{idle,                                    1,1,0,5'd0,32'h0,0,5'd0,0};

    do_cycle(rs);
    for (int i = 0; i < 20; i++) begin
      do_cycle(vt[i].s);
      chk($sformatf("v%0d_a_ready", i), a_ready, vt[i].ar);
      chk($sformatf("v%0d_ld_issue_ready", i), ld_issue_ready, vt[i].ir);
      chk($sformatf("v%0d_wr_en", i), wr_en, vt[i].we);
      chk($sformatf("v%0d_wr_addr", i), wr_addr, vt[i].wa);
      chk($sformatf("v%0d_wr_data", i), wr_data, vt[i].wd);
      chk($sformatf("v%0d_err_ret", i), err_ret, vt[i].err);
      chk($sformatf("v%0d_busy_bit", i), busy_mask[vt[i].bi], vt[i].bv);
    end

    // Four loads fill the queue; the fifth waits until the first write leaves.
    do_cycle(rs);
    for (int k = 1; k <= 4; k++) do_cycle(S(0, 1, 5'(k), 0, 0, 0, 0, 0));
    do_cycle(S(0, 1, 5, 0, 0, 0, 0, 0));
    chk("fill_issue_blocked", ld_issue_ready, 1'b0);
    chk("fill_busy", busy_mask, 32'h1E);
    wlog.delete();
    for (int k = 1; k <= 4; k++) do_cycle(S(0, 1, 5, 1, 32'(k * 16), 0, 0, 0));
    repeat (3) do_cycle(idle);
    chk("fill_write_count", wlog.size(), 4);
    for (int k = 0; k < 4 && k < wlog.size(); k++)
      chk($sformatf("fill_order%0d", k), wlog[k], 5'(k + 1));
    chk("fill_late_issue_busy5", busy_mask[5], 1'b1);

    // Pending load write beats a simultaneous execute request.
    do_cycle(rs);
    do_cycle(S(0, 1, 7, 0, 0, 0, 0, 0));
    do_cycle(S(0, 0, 0, 1, 32'h77, 0, 0, 0));
    do_cycle(S(0, 0, 0, 0, 0, 1, 6, 32'h66));
    chk("prio_a_blocked", a_ready, 1'b0);
    do_cycle(S(0, 0, 0, 0, 0, 1, 6, 32'h66));
    chk("prio_a_ready", a_ready, 1'b1);
    chk("prio_load_first", wr_addr, 5'd7);
    do_cycle(idle);
    chk("prio_a_addr", wr_addr, 5'd6);
    chk("prio_a_data", wr_data, 32'h66);

    // r0 writes are swallowed; reset mid-queue; orphan return raises err_ret.
    do_cycle(rs);
    do_cycle(S(0, 1, 0, 0, 0, 1, 0, 32'h5555));
    do_cycle(S(0, 0, 0, 1, 32'h1234, 0, 0, 0));
    chk("r0_a_no_write", wr_en, 1'b0);
    do_cycle(idle);
    do_cycle(S(0, 1, 10, 0, 0, 0, 0, 0));
    chk("r0_load_no_write", wr_en, 1'b0);
    do_cycle(S(0, 1, 11, 0, 0, 0, 0, 0));
    do_cycle(S(0, 0, 0, 1, 32'hAB, 0, 0, 0));
    do_cycle(rs);
    chk("rst_issue_ready", ld_issue_ready, 1'b0);
    do_cycle(S(0, 1, 11, 1, 32'hCD, 0, 0, 0));
    chk("rst_busy_clear", busy_mask, 32'h0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_issue_r11_ok", ld_issue_ready, 1'b1);
    do_cycle(idle);
    chk("orphan_err", err_ret, 1'b1);

    // Random traffic against the model.
    do_cycle(rs);
    for (int c = 0; c < 2000; c++) begin
      stim_t r;
      r.rst = ($urandom_range(63) == 0);
      r.iv  = $urandom_range(1);
      r.ia  = 5'($urandom_range(7));
      r.rv  = ($urandom_range(9) < 4);
      r.rd  = $urandom;
      r.av  = $urandom_range(1);
      r.aa  = 5'($urandom_range(7));
      r.ad  = $urandom;
      do_cycle(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
